operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 139 +++++++++++++
 tb/tb_operand_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch pipeline stage. It reads two source operands from an external
// register file, forwards the write-back value when it targets a source in the
// same cycle, and tracks pending destination writes in an 8-entry busy
// scoreboard. Read-after-write and write-after-write hazards are stalled here.
// A single execute register holds the issued instruction with 1-cycle latency
// and valid/ready flow control.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           decoded-instruction handshake
//   in_op, in_wr, in_rd           opcode, write enable, destination index
//   in_rs0, in_rs1                source register indices
//   in_use_imm, in_imm            operand B select and immediate
//   rf_rd0_addr / rf_rd1_addr     register-file read addresses (= rs0 / rs1)
//   rf_rd0_data / rf_rd1_data     register-file read data (combinational)
//   wb_en, wb_addr, wb_data       write-back port into the register file
//   out_valid / out_ready         execute-register handshake
//   out_op, out_rd, out_wr,
//   out_a, out_b                  registered instruction and operands
//   stall_cnt                     saturating count of stalled input cycles
// -----------------------------------------------------------------------------
module operand_fetch #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_op,
   input  logic                   in_wr,
   input  logic [2:0]             in_rd,
   input  logic [2:0]             in_rs0,
   input  logic [2:0]             in_rs1,
   input  logic                   in_use_imm,
   input  logic [15:0]            in_imm,

   output logic [2:0]             rf_rd0_addr,
   output logic [2:0]             rf_rd1_addr,
   input  logic [15:0]            rf_rd0_data,
   input  logic [15:0]            rf_rd1_data,

   input  logic                   wb_en,
   input  logic [2:0]             wb_addr,
   input  logic [15:0]            wb_data,

   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0]             out_op,
   output logic [2:0]             out_rd,
   output logic                   out_wr,
   output logic [15:0]            out_a,
   output logic [15:0]            out_b,

   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic [7:0]  busy;
   logic [7:0]  busy_nxt;
   logic        wb_hit_rs0;
   logic        wb_hit_rs1;
   logic        wb_hit_rd;
   logic        hazard;
   logic        accept;
   logic [15:0] op_a;
   logic [15:0] op_b;

   assign rf_rd0_addr = in_rs0;
   assign rf_rd1_addr = in_rs1;

   // A write-back landing this cycle both forwards its data and releases the
   // busy bit early, so a matching register is never considered blocked.
   assign wb_hit_rs0 = wb_en && (wb_addr == in_rs0);
   assign wb_hit_rs1 = wb_en && (wb_addr == in_rs1);
   assign wb_hit_rd  = wb_en && (wb_addr == in_rd);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      hazard   = 1'b0;
      op_a     = rf_rd0_data;
      op_b     = rf_rd1_data;
      busy_nxt = busy;

      if (wb_hit_rs0) op_a = wb_data;
      if (in_use_imm) op_b = in_imm;
      else if (wb_hit_rs1) op_b = wb_data;

      // Hazard is evaluated regardless of in_valid so in_ready is a pure
      // function of the presented fields and current state.
      if (busy[in_rs0] && !wb_hit_rs0)                hazard = 1'b1;
      if (!in_use_imm && busy[in_rs1] && !wb_hit_rs1) hazard = 1'b1;
      if (in_wr && busy[in_rd] && !wb_hit_rd)         hazard = 1'b1;

      // Clear before set: a same-cycle set to the same index wins.
      if (wb_en)           busy_nxt[wb_addr] = 1'b0;
      if (accept && in_wr) busy_nxt[in_rd]   = 1'b1;
   end

   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignment so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         // NOTE: the busy scoreboard must be cleared on reset; a stale bit
         // would stall any reader of that register forever.
         busy      <= '0;
         out_valid <= 1'b0;
         out_op    <= '0;
         out_rd    <= '0;
         out_wr    <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         stall_cnt <= '0;
      end else begin
         busy <= busy_nxt;

         if (accept) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_rd    <= in_rd;
            out_wr    <= in_wr;
            out_a     <= op_a;
            out_b     <= op_b;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (in_valid && !in_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch. A small reference model tracks busy
// bits, execute-register valid and the stall counter; accepted instructions
// push their expected result into a queue that is popped when the execute
// register loads.
module tb_operand_fetch;

   localparam int SW = 4;  // narrow counter so saturation is reachable

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  rd;
      logic        wr;
      logic [15:0] a;
      logic [15:0] b;
   } item_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid, in_ready, in_wr, in_use_imm;
   logic [3:0]    in_op;
   logic [2:0]    in_rd, in_rs0, in_rs1;
   logic [15:0]   in_imm;
   logic [2:0]    rf_rd0_addr, rf_rd1_addr;
   logic [15:0]   rf_rd0_data, rf_rd1_data;
   logic          wb_en;
   logic [2:0]    wb_addr;
   logic [15:0]   wb_data;
   logic          out_valid, out_ready, out_wr;
   logic [3:0]    out_op;
   logic [2:0]    out_rd;
   logic [15:0]   out_a, out_b;
   logic [SW-1:0] stall_cnt;

   logic [15:0]   rf [8];
   assign rf_rd0_data = rf[rf_rd0_addr];
   assign rf_rd1_data = rf[rf_rd1_addr];

   logic [7:0]    m_busy;
   logic          m_ov;
   logic [SW-1:0] m_stall;
   item_t         exp_q[$];
   item_t         last_it;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   operand_fetch #(.STALL_CNT_W(SW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_wr(in_wr),
      .in_rd(in_rd), .in_rs0(in_rs0), .in_rs1(in_rs1),
      .in_use_imm(in_use_imm), .in_imm(in_imm),
      .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
      .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_rd(out_rd), .out_wr(out_wr), .out_a(out_a), .out_b(out_b),
      .stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic wr,
                        input logic [2:0] rd, input logic [2:0] rs0, input logic [2:0] rs1,
                        input logic ui, input logic [15:0] imm);
      in_valid = v;  in_op = op;   in_wr = wr;       in_rd = rd;
      in_rs0 = rs0;  in_rs1 = rs1; in_use_imm = ui;  in_imm = imm;
   endtask

   task automatic wb(input logic en, input logic [2:0] addr, input logic [15:0] data);
      wb_en = en; wb_addr = addr; wb_data = data;
   endtask

   // One clock cycle: check combinational outputs mid-cycle, update the model,
   // cross the edge, then check registered outputs 1 time unit after it.
   task automatic tick();
      logic  hz;
      logic  exp_rdy;
      logic  acc;
      item_t it;
      exp_rdy = 1'b0;
      #3;
      if (!rst) begin
         hz = (m_busy[in_rs0] && !(wb_en && wb_addr == in_rs0)) ||
              (!in_use_imm && m_busy[in_rs1] && !(wb_en && wb_addr == in_rs1)) ||
              (in_wr && m_busy[in_rd] && !(wb_en && wb_addr == in_rd));
         exp_rdy = (!m_ov || out_ready) && !hz;
         check("in_ready", 32'(in_ready), 32'(exp_rdy));
         check("rf_rd0_addr", 32'(rf_rd0_addr), 32'(in_rs0));
         check("rf_rd1_addr", 32'(rf_rd1_addr), 32'(in_rs1));
      end
      acc = !rst && in_valid && exp_rdy;
      if (acc) begin
         it.op = in_op;
         it.rd = in_rd;
         it.wr = in_wr;
         it.a  = (wb_en && wb_addr == in_rs0) ? wb_data : rf[in_rs0];
         it.b  = in_use_imm ? in_imm :
                 (wb_en && wb_addr == in_rs1) ? wb_data : rf[in_rs1];
         exp_q.push_back(it);
      end
      if (rst) begin
         m_busy  = '0;
         m_ov    = 1'b0;
         m_stall = '0;
         last_it = '0;
         exp_q.delete();
      end else begin
         if (in_valid && !exp_rdy && m_stall != {SW{1'b1}}) m_stall = m_stall + 1'b1;
         if (wb_en) m_busy[wb_addr] = 1'b0;
         if (acc && in_wr) m_busy[in_rd] = 1'b1;
         if (acc) m_ov = 1'b1;
         else if (out_ready) m_ov = 1'b0;
      end
      @(posedge clk);
      if (wb_en) rf[wb_addr] = wb_data;
      #1;
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (acc && exp_q.size() != 0 && out_valid) last_it = exp_q.pop_front();
      if (acc || m_ov || rst) begin
         check("out_op", 32'(out_op), 32'(last_it.op));
         check("out_rd", 32'(out_rd), 32'(last_it.rd));
         check("out_wr", 32'(out_wr), 32'(last_it.wr));
         check("out_a",  32'(out_a),  32'(last_it.a));
         check("out_b",  32'(out_b),  32'(last_it.b));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 16'h0100 * i[15:0] + 16'h000A;
      m_busy = '0; m_ov = 1'b0; m_stall = '0; last_it = '0;
      out_ready = 1'b1;
      // Reset with in_valid and wb_en active: both must be ignored.
      drive(1'b1, 4'h1, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0);
      wb(1'b1, 3'd2, 16'hFFFF);
      tick();
      tick();
      rst = 1'b0;
      wb(1'b0, 3'd0, 16'h0);

      // Basic fetch, first cycle after reset.
      rf[2] = 16'h1111; rf[3] = 16'h2222;
      drive(1'b1, 4'h2, 1'b0, 3'd0, 3'd2, 3'd3, 1'b0, 16'h0);
      tick();
      check("basic_a", 32'(out_a), 32'h1111);
      check("basic_b", 32'(out_b), 32'h2222);

      // Bypass on rs0.
      rf[5] = 16'h0000;
      drive(1'b1, 4'h3, 1'b0, 3'd0, 3'd5, 3'd3, 1'b0, 16'h0);
      wb(1'b1, 3'd5, 16'hBEEF);
      tick();
      check("bypass_a", 32'(out_a), 32'hBEEF);
      wb(1'b0, 3'd0, 16'h0);

      // RAW stall on r4 for three cycles, released by write-back.
      drive(1'b1, 4'h4, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0);
      tick();
      drive(1'b1, 4'h5, 1'b0, 3'd0, 3'd4, 3'd0, 1'b0, 16'h0);
      repeat (3) tick();
      check("raw_stall_cnt", 32'(stall_cnt), 32'd3);
      wb(1'b1, 3'd4, 16'h4444);
      tick();
      check("raw_release_a", 32'(out_a), 32'h4444);
      wb(1'b0, 3'd0, 16'h0);

      // Backpressure for two cycles, then same-cycle accept.
      drive(1'b1, 4'h6, 1'b0, 3'd0, 3'd1, 3'd0, 1'b1, 16'h1234);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 4'h7, 1'b0, 3'd0, 3'd1, 3'd0, 1'b1, 16'h5678);
      repeat (2) tick();
      check("bp_hold_b", 32'(out_b), 32'h1234);
      out_ready = 1'b1;
      tick();
      check("bp_accept_b", 32'(out_b), 32'h5678);

      // Same-cycle set/clear on r6: set wins, reader stalls.
      drive(1'b1, 4'h8, 1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0);
      tick();
      drive(1'b1, 4'h9, 1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0);
      wb(1'b1, 3'd6, 16'h0606);
      tick();
      wb(1'b0, 3'd0, 16'h0);
      drive(1'b1, 4'hA, 1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 16'h0);
      tick();
      check("setwin_stall", 32'(out_valid), 32'd0);
      wb(1'b1, 3'd6, 16'h6666);
      tick();
      wb(1'b0, 3'd0, 16'h0);

      // Write-back hitting both sources.
      drive(1'b1, 4'hB, 1'b0, 3'd0, 3'd2, 3'd2, 1'b0, 16'h0);
      wb(1'b1, 3'd2, 16'hCAFE);
      tick();
      check("dual_bypass_a", 32'(out_a), 32'hCAFE);
      check("dual_bypass_b", 32'(out_b), 32'hCAFE);

      // Write-back to a non-busy register is harmless.
      drive(1'b1, 4'hC, 1'b0, 3'd0, 3'd3, 3'd1, 1'b0, 16'h0);
      wb(1'b1, 3'd3, 16'h3333);
      tick();
      wb(1'b0, 3'd0, 16'h0);
      tick();

      // Back-to-back accepts.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'(i), 1'b0, 3'd0, 3'(i), 3'd0, 1'b1, 16'hA000 + 16'(i));
         tick();
      end

      // Stall counter saturation.
      drive(1'b1, 4'hD, 1'b1, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0);
      tick();
      drive(1'b1, 4'hE, 1'b0, 3'd0, 3'd7, 3'd0, 1'b0, 16'h0);
      repeat (12) tick();
      check("stall_sat", 32'(stall_cnt), 32'hF);
      wb(1'b1, 3'd7, 16'h7777);
      tick();
      wb(1'b0, 3'd0, 16'h0);

      // Reset mid-stream with a held instruction and busy r1.
      drive(1'b1, 4'hF, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0);
      tick();
      out_ready = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 4'h1, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0);
      tick();
      check("post_rst_accept", 32'(out_valid), 32'd1);
      drive(1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
      out_ready = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
